// File: rtl/itlb_buffer_pkg.sv
// Shared definitions for the instruction-side TLB buffer and the segment decoder.
package itlb_buffer_pkg;

    // Main TLB entry layout: one VPN2 maps an even/odd page pair.
    typedef struct packed {
        logic [18:0] VPN2;
        logic [7:0]  ASID;
        logic        G;
        logic [19:0] PFN0;
        logic [2:0]  C0;
        logic        D0;
        logic        V0;
        logic [19:0] PFN1;
        logic [2:0]  C1;
        logic        D1;
        logic        V1;
    } TLB_Entry;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } itlb_state_t;

    localparam logic [2:0] SEG_KSEG0         = 3'b100;
    localparam logic [2:0] SEG_KSEG1         = 3'b101;
    localparam logic [2:0] CACHE_ATTR_CACHED = 3'b011;

endpackage

// File: rtl/itlb_buffer_vaddr_seg_decode.sv
// Combinational virtual segment decode: mapped flag plus unmapped translation.
module vaddr_seg_decode
    import itlb_buffer_pkg::*;
(
    input  logic [31:0] vaddr,
    input  logic [2:0]  cfg_k0,
    output logic        mapped,
    output logic [31:0] paddr,
    output logic        cacheable
);

    // kseg0/kseg1 strip the top three bits; everything else goes through the TLB.
    always_comb begin
        mapped    = 1'b1;
        paddr     = {3'b000, vaddr[28:0]};
        cacheable = 1'b0;
        if (vaddr[31:29] == SEG_KSEG0) begin
            mapped    = 1'b0;
            cacheable = (cfg_k0 == CACHE_ATTR_CACHED);
        end else if (vaddr[31:29] == SEG_KSEG1) begin
            mapped    = 1'b0;
        end
    end

endmodule

// File: rtl/itlb_buffer.sv
// Single-entry instruction TLB buffer in front of main TLB search port 0.
module itlb_buffer
    import itlb_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_vaddr,
    input  logic [7:0]  cp0_asid,
    input  logic [2:0]  cfg_k0,
    input  logic        tlbw_inv,
    input  logic        asid_chg,
    input  logic        flush,
    output logic [18:0] tlb_vpn2,
    input  logic        tlb_found,
    input  TLB_Entry    tlb_entry,
    output logic [31:0] paddr,
    output logic        cacheable,
    output logic        stall,
    output logic        exc_refill,
    output logic        exc_invalid
);

    itlb_state_t state;
    TLB_Entry    entry;
    logic        valid;
    logic        nf_valid;
    logic [18:0] nf_vpn2;
    logic [18:0] search_vpn2;

    logic        mapped;
    logic [31:0] seg_paddr;
    logic        seg_cacheable;

    logic        active;
    logic        hit;
    logic        nf_hit;
    logic        miss;
    logic [19:0] sel_pfn;
    logic [2:0]  sel_c;
    logic        sel_v;
    logic        invalidate;
    logic        unused_dirty;

    vaddr_seg_decode u_seg (
        .vaddr     (req_vaddr),
        .cfg_k0    (cfg_k0),
        .mapped    (mapped),
        .paddr     (seg_paddr),
        .cacheable (seg_cacheable)
    );

    assign tlb_vpn2     = search_vpn2;
    assign invalidate   = tlbw_inv | asid_chg;
    assign unused_dirty = entry.D0 ^ entry.D1;

    // Buffer lookup, page select and the fetch-facing response.
    always_comb begin
        active  = req_valid && !flush;
        hit     = valid && (entry.VPN2 == req_vaddr[31:13]) &&
                  ((entry.ASID == cp0_asid) || entry.G);
        nf_hit  = nf_valid && (nf_vpn2 == req_vaddr[31:13]);
        sel_pfn = req_vaddr[12] ? entry.PFN1 : entry.PFN0;
        sel_c   = req_vaddr[12] ? entry.C1   : entry.C0;
        sel_v   = req_vaddr[12] ? entry.V1   : entry.V0;
        miss    = mapped && !hit && !nf_hit;

        if (mapped) begin
            paddr     = {sel_pfn, req_vaddr[11:0]};
            cacheable = (sel_c == CACHE_ATTR_CACHED);
        end else begin
            paddr     = seg_paddr;
            cacheable = seg_cacheable;
        end

        exc_invalid = active && mapped && hit && !sel_v;
        exc_refill  = active && mapped && !hit && nf_hit;
        stall       = active && (miss || (state == SEARCH));
    end

    // Miss FSM: latch the VPN2, search the main TLB for one cycle, then fill or record not-found.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            entry       <= '0;
            valid       <= 1'b0;
            nf_valid    <= 1'b0;
            nf_vpn2     <= '0;
            search_vpn2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (active && miss) begin
                        search_vpn2 <= req_vaddr[31:13];
                        state       <= SEARCH;
                    end
                end
                SEARCH: begin
                    state <= IDLE;
                    if (!flush && !invalidate) begin
                        if (tlb_found) begin
                            entry    <= tlb_entry;
                            valid    <= 1'b1;
                            nf_valid <= 1'b0;
                        end else begin
                            nf_valid <= 1'b1;
                            nf_vpn2  <= search_vpn2;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Invalidation wins over anything written above in the same cycle.
            if (invalidate) begin
                valid    <= 1'b0;
                nf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_itlb_buffer.sv
// Scoreboard bench for itlb_buffer: driver queues expectations, monitor checks at negedge.
module tb_itlb_buffer;
    import itlb_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_vaddr;
    logic [7:0]  cp0_asid;
    logic [2:0]  cfg_k0;
    logic        tlbw_inv;
    logic        asid_chg;
    logic        flush;
    logic [18:0] tlb_vpn2;
    logic        tlb_found;
    TLB_Entry    tlb_entry;
    logic [31:0] paddr;
    logic        cacheable;
    logic        stall;
    logic        exc_refill;
    logic        exc_invalid;

    logic        main_has;
    TLB_Entry    main_entry;

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;
    bit done   = 1'b0;

    typedef struct {
        int          cyc;
        string       name;
        bit          chk_pa;
        logic [31:0] pa;
        logic        ca;
        logic        st;
        logic        rf;
        logic        inv;
        bit          chk_vpn;
        logic [18:0] vpn;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main TLB model: hits only when the presented VPN2 matches its single entry.
    assign tlb_found = main_has && (tlb_vpn2 == main_entry.VPN2);
    assign tlb_entry = main_entry;

    itlb_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_vaddr   (req_vaddr),
        .cp0_asid    (cp0_asid),
        .cfg_k0      (cfg_k0),
        .tlbw_inv    (tlbw_inv),
        .asid_chg    (asid_chg),
        .flush       (flush),
        .tlb_vpn2    (tlb_vpn2),
        .tlb_found   (tlb_found),
        .tlb_entry   (tlb_entry),
        .paddr       (paddr),
        .cacheable   (cacheable),
        .stall       (stall),
        .exc_refill  (exc_refill),
        .exc_invalid (exc_invalid)
    );

    function automatic TLB_Entry mk(input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                                    input logic [19:0] pfn0, input logic [2:0] c0, input logic v0,
                                    input logic [19:0] pfn1, input logic [2:0] c1, input logic v1);
        TLB_Entry e;
        e = '0;
        e.VPN2 = vpn2; e.ASID = asid; e.G = g;
        e.PFN0 = pfn0; e.C0 = c0; e.V0 = v0; e.D0 = 1'b1;
        e.PFN1 = pfn1; e.C1 = c1; e.V1 = v1; e.D1 = 1'b0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: compare the DUT against every expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.chk_pa) begin
                chk({e.name, ".paddr"}, paddr, e.pa);
                chk({e.name, ".cacheable"}, {31'd0, cacheable}, {31'd0, e.ca});
            end
            chk({e.name, ".stall"}, {31'd0, stall}, {31'd0, e.st});
            chk({e.name, ".exc_refill"}, {31'd0, exc_refill}, {31'd0, e.rf});
            chk({e.name, ".exc_invalid"}, {31'd0, exc_invalid}, {31'd0, e.inv});
            if (e.chk_vpn)
                chk({e.name, ".tlb_vpn2"}, {13'd0, tlb_vpn2}, {13'd0, e.vpn});
        end
    end

    // Queue an expectation for the current cycle, then advance one clock.
    task automatic go(input string name, input bit chk_pa, input logic [31:0] pa, input logic ca,
                      input logic st, input logic rf, input logic inv,
                      input bit chk_vpn, input logic [18:0] vpn);
        exp_t e;
        e.cyc = cyc; e.name = name; e.chk_pa = chk_pa; e.pa = pa; e.ca = ca;
        e.st = st; e.rf = rf; e.inv = inv; e.chk_vpn = chk_vpn; e.vpn = vpn;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    TLB_Entry e1, e2, e2g;

    initial begin
        e1  = mk(19'h00201, 8'd5, 1'b0, 20'h12345, 3'd3, 1'b1, 20'h0F00D, 3'd2, 1'b1);
        e2  = mk(19'h00300, 8'd5, 1'b0, 20'h11111, 3'd3, 1'b0, 20'h22222, 3'd3, 1'b1);
        e2g = e2; e2g.G = 1'b1;

        rst = 1'b1; req_valid = 1'b0; req_vaddr = '0; cp0_asid = 8'd5; cfg_k0 = 3'd3;
        tlbw_inv = 1'b0; asid_chg = 1'b0; flush = 1'b0; main_has = 1'b0; main_entry = e1;
        repeat (2) @(posedge clk);
        #1;
        go("reset", 0, 0, 0, 0, 0, 0, 1, 19'h0);
        rst = 1'b0;

        // Unmapped segments
        req_valid = 1'b1; req_vaddr = 32'hBFC0_0000;
        go("kseg1", 1, 32'h1FC0_0000, 0, 0, 0, 0, 0, 0);
        req_vaddr = 32'h8000_1000;
        go("kseg0_k3", 1, 32'h0000_1000, 1, 0, 0, 0, 0, 0);
        cfg_k0 = 3'd2;
        go("kseg0_k2", 1, 32'h0000_1000, 0, 0, 0, 0, 0, 0);
        cfg_k0 = 3'd3;

        // Miss then refill
        main_has = 1'b1; main_entry = e1; req_vaddr = 32'h0040_2004;
        go("miss_c0", 0, 0, 0, 1, 0, 0, 1, 19'h0);
        go("miss_c1", 0, 0, 0, 1, 0, 0, 1, 19'h00201);
        go("fill_hit", 1, 32'h1234_5004, 1, 0, 0, 0, 0, 0);
        req_vaddr = 32'h0040_3008;
        go("odd_hit", 1, 32'h0F00_D008, 0, 0, 0, 0, 0, 0);
        req_valid = 1'b0;
        go("no_req", 0, 0, 0, 0, 0, 0, 0, 0);

        // Not found
        main_has = 1'b0; req_valid = 1'b1; req_vaddr = 32'h0080_0000;
        go("nf_c0", 0, 0, 0, 1, 0, 0, 1, 19'h00201);
        go("nf_c1", 0, 0, 0, 1, 0, 0, 1, 19'h00400);
        go("nf_refill", 0, 0, 0, 0, 1, 0, 0, 0);
        flush = 1'b1;
        go("nf_flush", 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b0; req_vaddr = 32'h00A0_0000;
        go("nf2_c0", 0, 0, 0, 1, 0, 0, 0, 0);
        go("nf2_c1", 0, 0, 0, 1, 0, 0, 1, 19'h00500);
        go("nf2_refill", 0, 0, 0, 0, 1, 0, 0, 0);
        req_vaddr = 32'h0080_0000;
        go("nf_replaced_c0", 0, 0, 0, 1, 0, 0, 0, 0);
        go("nf_replaced_c1", 0, 0, 0, 1, 0, 0, 1, 19'h00400);
        go("nf_replaced_rf", 0, 0, 0, 0, 1, 0, 0, 0);

        // Invalid page
        main_has = 1'b1; main_entry = e2; req_vaddr = 32'h0060_0010;
        go("inv_c0", 0, 0, 0, 1, 0, 0, 0, 0);
        go("inv_c1", 0, 0, 0, 1, 0, 0, 1, 19'h00300);
        go("inv_exc", 1, 32'h1111_1010, 1, 0, 0, 1, 0, 0);

        // ASID change: hit still honoured in the same cycle, then misses
        req_vaddr = 32'h0060_1010; asid_chg = 1'b1;
        go("asidchg_hit", 1, 32'h2222_2010, 1, 0, 0, 0, 0, 0);
        asid_chg = 1'b0; cp0_asid = 8'd6; main_entry = e2g;
        go("asid_miss_c0", 0, 0, 0, 1, 0, 0, 0, 0);
        go("asid_miss_c1", 0, 0, 0, 1, 0, 0, 1, 19'h00300);
        go("global_hit", 1, 32'h2222_2010, 1, 0, 0, 0, 0, 0);
        cp0_asid = 8'h77;
        go("global_other_asid", 1, 32'h2222_2010, 1, 0, 0, 0, 0, 0);

        // tlbw_inv during SEARCH discards the fill
        cp0_asid = 8'd5; main_entry = e1; req_vaddr = 32'h0040_2004;
        go("tlbw_c0", 0, 0, 0, 1, 0, 0, 0, 0);
        tlbw_inv = 1'b1;
        go("tlbw_c1", 0, 0, 0, 1, 0, 0, 1, 19'h00201);
        tlbw_inv = 1'b0;
        go("tlbw_remiss", 0, 0, 0, 1, 0, 0, 0, 0);
        go("tlbw_search", 0, 0, 0, 1, 0, 0, 1, 19'h00201);
        go("tlbw_hit", 1, 32'h1234_5004, 1, 0, 0, 0, 0, 0);

        // flush during SEARCH discards the fill
        main_entry = e2g; req_vaddr = 32'h0060_0010;
        go("flush_c0", 0, 0, 0, 1, 0, 0, 0, 0);
        flush = 1'b1;
        go("flush_c1", 0, 0, 0, 0, 0, 0, 1, 19'h00300);
        flush = 1'b0;
        go("flush_remiss", 0, 0, 0, 1, 0, 0, 0, 0);
        go("flush_search", 0, 0, 0, 1, 0, 0, 1, 19'h00300);
        go("flush_inv", 1, 32'h1111_1010, 1, 0, 0, 1, 0, 0);

        // Reset in the middle of SEARCH
        main_entry = e1; req_vaddr = 32'h0040_2004;
        go("rst_c0", 0, 0, 0, 1, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        go("rst_after", 0, 0, 0, 0, 0, 0, 1, 19'h0);
        main_entry = e2g; req_valid = 1'b1; req_vaddr = 32'h0060_0010;
        go("rst_cleared_c0", 0, 0, 0, 1, 0, 0, 0, 0);
        go("rst_cleared_c1", 0, 0, 0, 1, 0, 0, 1, 19'h00300);
        go("rst_cleared_inv", 1, 32'h1111_1010, 1, 0, 0, 1, 0, 0);

        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL timeout: simulation did not complete, expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
